rr_enq_arbiter: RTL and testbench
=================================

Name: rr_enq_arbiter

Overview:
- Shares one downstream guarded enq port between two upstream requesters, each with its own enq method.
- Replaces the fixed-priority combinational merge used in front of shared pipes with a registered, fair, burst-limited round-robin scheduler.
- Each requester gets a one-entry holding slot, so upstream RDY never depends combinationally on downstream RDY.
- Sits between request producers (e.g. forward path and new-request path) and a shared pipe or FIFO input.

Parameters:
- WIDTH, 128, payload width of every enq$v.
- MAX_BURST, 4, maximum consecutive grants to one requester while the other has a full slot (legal range 1..15).
- CNT_W, 16, width of per-requester grant counters.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- nRST  input  1  synchronous reset, active-high (asserted = 1), sampled on posedge CLK.
- in0$enq__ENA  input  1  requester 0 enqueue strobe; legal only when in0$enq__RDY=1.
- in0$enq$v  input  WIDTH  requester 0 payload.
- in0$enq__RDY  output  1  requester 0 slot empty.
- in1$enq__ENA  input  1  requester 1 enqueue strobe.
- in1$enq$v  input  WIDTH  requester 1 payload.
- in1$enq__RDY  output  1  requester 1 slot empty.
- out$enq__ENA  output  1  downstream enqueue strobe.
- out$enq$v  output  WIDTH  downstream payload (granted slot data).
- out$enq__RDY  input  1  downstream can accept.
- out$grant  output  1  index of the slot driving out$enq$v; valid when out$enq__ENA=1.
- grant_count0  output  CNT_W  total grants to requester 0.
- grant_count1  output  CNT_W  total grants to requester 1.
- idle  output  1  both slots empty.

Behaviour:
- State:
  - full0/full1 and data0/data1: the two holding slots.
  - ptr (1 bit): priority owner.
  - burst (4 bits): consecutive grants to ptr.
  - grant_count0/1.
- Reset (nRST=1 at posedge):
  - full0=full1=0, ptr=0, burst=0, counts=0, data=0.
  - Outputs during/after reset: inN$enq__RDY=1, out$enq__ENA=0, out$enq$v=0, out$grant=0, idle=1.
  - Reset mid-operation discards held entries with no output strobe.
  - Enqueues presented in a reset cycle are ignored.
- Enqueue:
  - inN$enq__RDY = !fullN.
  - On inN$enq__ENA: dataN <= v and fullN <= 1 next edge.
  - Enqueue while full is illegal; the design ignores it and keeps the old data.
  - No bypass: an entry enqueued at edge k is offered to the output no earlier than cycle k+1. Minimum latency is 1 cycle.
- Grant selection (combinational, from registered state only):
  - pref = ptr.
  - If burst == MAX_BURST and full[!ptr], then pref = !ptr.
  - grant = pref if full[pref], otherwise the other slot.
  - out$enq__ENA = (full0|full1) & out$enq__RDY.
  - out$enq$v = data[grant]; out$grant = grant.
  - When no slot is full, out$enq$v = data0 (don't-care; stable).
- On a grant (out$enq__ENA=1):
  - full[grant] <= 0.
  - grant_count[grant] increments, wrapping at 2^CNT_W.
  - If grant == ptr: burst <= burst+1, saturating at MAX_BURST.
  - If grant != ptr: ptr <= grant, burst <= 1.
- A slot dequeued at edge k may be re-enqueued in cycle k (RDY=1 from cycle k). Single-requester throughput is 1 per 2 cycles; aggregate throughput is 1 per cycle when both slots are kept busy.
- When out$enq__RDY=0: no state change except enqueues into empty slots. out$enq$v and out$grant still reflect the pending choice.
- Simultaneous enq into slot A and grant of slot B in the same cycle are both performed.
- idle = !full0 & !full1.

Test Plan:
- Reset then idle: nRST=1 for 2 cycles, then 0 → in0/in1 RDY=1, out$enq__ENA=0, idle=1, counts=0.
- Single entry latency: in0 enq v=0xA5 at cycle 0, out RDY=1 → cycle 1 out$enq__ENA=1, v=0xA5, grant=0; cycle 2 ENA=0, grant_count0=1.
- Both requesters saturated (re-enqueue each slot on every RDY), MAX_BURST=4, out RDY=1 → grants alternate 0,1,0,1…. In this mode each requester's slot is only full every other cycle, so the burst limit is never reached.
- Burst limit: hold full1=1 with out RDY=0 while slot 0 is continuously refilled ahead, then raise out RDY → at most 4 consecutive grant=0 before a grant=1 appears. Pass criterion: no run of grant=0 longer than 4 while full1=1.
- Backpressure: both slots full, out RDY=0 for 5 cycles → ENA=0, inN RDY=0, counts unchanged. RDY=1 → grants in ptr order, one per cycle.
- Reset mid-operation: both slots full, assert nRST for 1 cycle → no out$enq__ENA, idle=1, counts=0. A new in1 enq is delivered with grant=1.
- Counter wrap: CNT_W=4, 17 grants to requester 0 → grant_count0=1.

Source files
------------

// File: rtl/rr_enq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_enq_arbiter
// Brief    : Merges two guarded enq requesters onto one downstream enq port
//            through one-entry holding slots and a burst-limited round robin.
// Revision : 1.0 - initial release
// ============================================================================
module rr_enq_arbiter #(
    parameter int WIDTH     = 128,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             nRST,

    input  logic             in0_enq__ENA,
    input  logic [WIDTH-1:0] in0_enq_v,
    output logic             in0_enq__RDY,

    input  logic             in1_enq__ENA,
    input  logic [WIDTH-1:0] in1_enq_v,
    output logic             in1_enq__RDY,

    output logic             out_enq__ENA,
    output logic [WIDTH-1:0] out_enq_v,
    input  logic             out_enq__RDY,
    output logic             out_grant,

    output logic [CNT_W-1:0] grant_count0,
    output logic [CNT_W-1:0] grant_count1,
    output logic             idle
);

    if ((MAX_BURST < 1) || (MAX_BURST > 15)) begin : g_bad_max_burst
        $error("rr_enq_arbiter: MAX_BURST must lie in 1..15");
    end

    localparam logic [3:0] c_max_burst = 4'(MAX_BURST);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [1:0]       r_full;
    logic [WIDTH-1:0] r_data0;
    logic [WIDTH-1:0] r_data1;
    logic             r_ptr;
    logic [3:0]       r_burst;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [1:0] w_full;
    logic       w_pref;
    logic       w_grant;
    logic       w_fire;
    logic       w_enq0;
    logic       w_enq1;
    logic       w_deq0;
    logic       w_deq1;

    // Held entries are invisible while reset is asserted, so a mid-run
    // reset never produces an output strobe for data about to be dropped.
    assign w_full = r_full & {2{~nRST}};

    always_comb begin
        w_pref = r_ptr;
        if ((r_burst == c_max_burst) && w_full[~r_ptr]) begin
            w_pref = ~r_ptr;
        end

        w_grant = 1'b0;
        if (w_full != 2'b00) begin
            w_grant = w_full[w_pref] ? w_pref : ~w_pref;
        end
    end

    assign w_fire = (|w_full) & out_enq__RDY;
    assign w_deq0 = w_fire & ~w_grant;
    assign w_deq1 = w_fire &  w_grant;

    // Enqueue into an occupied slot is dropped; the held entry is kept.
    assign w_enq0 = in0_enq__ENA & ~r_full[0] & ~nRST;
    assign w_enq1 = in1_enq__ENA & ~r_full[1] & ~nRST;

    // ------------------------------------------------------------------
    // Holding slots
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (nRST) begin
            r_full  <= 2'b00;
            r_data0 <= '0;
            r_data1 <= '0;
        end else begin
            r_full[0] <= (r_full[0] & ~w_deq0) | w_enq0;
            r_full[1] <= (r_full[1] & ~w_deq1) | w_enq1;
            if (w_enq0) begin
                r_data0 <= in0_enq_v;
            end
            if (w_enq1) begin
                r_data1 <= in1_enq_v;
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin pointer and burst tracking
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (nRST) begin
            r_ptr   <= 1'b0;
            r_burst <= 4'd0;
        end else if (w_fire) begin
            if (w_grant == r_ptr) begin
                if (r_burst < c_max_burst) begin
                    r_burst <= r_burst + 4'd1;
                end
            end else begin
                r_ptr   <= w_grant;
                r_burst <= 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Grant statistics, free-running with natural wrap
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (nRST) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_deq0) begin
                r_cnt0 <= r_cnt0 + CNT_W'(1);
            end
            if (w_deq1) begin
                r_cnt1 <= r_cnt1 + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in0_enq__RDY = ~w_full[0];
    assign in1_enq__RDY = ~w_full[1];

    assign out_enq__ENA = w_fire;
    assign out_grant    = w_grant;
    assign out_enq_v    = nRST    ? '0      :
                          w_grant ? r_data1 : r_data0;

    assign grant_count0 = r_cnt0;
    assign grant_count1 = r_cnt1;
    assign idle         = ~(|w_full);

endmodule
`default_nettype wire

// File: tb/tb_rr_enq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_enq_arbiter
// Brief    : Scenario tasks plus a per-cycle scoreboard monitor for rr_enq_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rr_enq_arbiter;

    localparam int W  = 128;
    localparam int MB = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in0_ena = 1'b0, in1_ena = 1'b0, out_rdy = 1'b0;
    logic [W-1:0] in0_v = '0, in1_v = '0;
    logic         in0_rdy, in1_rdy, out_ena, out_grant, idle;
    logic [W-1:0] out_v;
    logic [15:0]  cnt0, cnt1;
    logic         s_in0_rdy, s_in1_rdy, s_out_ena, s_out_grant, s_idle;
    logic [W-1:0] s_out_v;
    logic [3:0]   s_cnt0, s_cnt1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rr_enq_arbiter #(.WIDTH(W), .MAX_BURST(MB), .CNT_W(16)) dut (
        .CLK(clk), .nRST(rst),
        .in0_enq__ENA(in0_ena), .in0_enq_v(in0_v), .in0_enq__RDY(in0_rdy),
        .in1_enq__ENA(in1_ena), .in1_enq_v(in1_v), .in1_enq__RDY(in1_rdy),
        .out_enq__ENA(out_ena), .out_enq_v(out_v), .out_enq__RDY(out_rdy),
        .out_grant(out_grant), .grant_count0(cnt0), .grant_count1(cnt1),
        .idle(idle)
    );

    // Narrow-counter instance sharing the same stimulus, for the wrap check.
    rr_enq_arbiter #(.WIDTH(W), .MAX_BURST(MB), .CNT_W(4)) dut_w (
        .CLK(clk), .nRST(rst),
        .in0_enq__ENA(in0_ena), .in0_enq_v(in0_v), .in0_enq__RDY(s_in0_rdy),
        .in1_enq__ENA(in1_ena), .in1_enq_v(in1_v), .in1_enq__RDY(s_in1_rdy),
        .out_enq__ENA(s_out_ena), .out_enq_v(s_out_v), .out_enq__RDY(out_rdy),
        .out_grant(s_out_grant), .grant_count0(s_cnt0), .grant_count1(s_cnt1),
        .idle(s_idle)
    );

    // ------------------------------------------------------------------
    // Scoreboard: accepted payloads queue per requester, popped on grants
    // ------------------------------------------------------------------
    logic [W-1:0] m_q0[$];
    logic [W-1:0] m_q1[$];
    bit           lg_grant[$];
    bit           lg_full1[$];
    bit           mon_en = 1'b0;
    bit           m_ptr = 1'b0;
    int           m_burst = 0;
    logic [15:0]  m_cnt0 = '0, m_cnt1 = '0;
    bit           n0, n1, pref, g, e_ena;
    logic [W-1:0] e_v;

    always @(negedge clk) begin
        if (mon_en) begin
            n0 = !rst && (m_q0.size() != 0);
            n1 = !rst && (m_q1.size() != 0);
            checks += 6;
            if (in0_rdy !== !n0) begin failures++; $display("FAIL mon_in0_rdy act=%b exp=%b t=%0t", in0_rdy, !n0, $time); end
            if (in1_rdy !== !n1) begin failures++; $display("FAIL mon_in1_rdy act=%b exp=%b t=%0t", in1_rdy, !n1, $time); end
            if (idle !== !(n0 || n1)) begin failures++; $display("FAIL mon_idle act=%b exp=%b t=%0t", idle, !(n0 || n1), $time); end
            e_ena = (n0 || n1) && out_rdy;
            if (out_ena !== e_ena) begin failures++; $display("FAIL mon_out_ena act=%b exp=%b t=%0t", out_ena, e_ena, $time); end
            if (cnt0 !== m_cnt0) begin failures++; $display("FAIL mon_cnt0 act=%0d exp=%0d t=%0t", cnt0, m_cnt0, $time); end
            if (cnt1 !== m_cnt1) begin failures++; $display("FAIL mon_cnt1 act=%0d exp=%0d t=%0t", cnt1, m_cnt1, $time); end
            if (e_ena) begin
                pref = m_ptr;
                if (m_burst == MB && (m_ptr ? n0 : n1)) pref = !m_ptr;
                g   = (pref ? n1 : n0) ? pref : !pref;
                e_v = g ? m_q1.pop_front() : m_q0.pop_front();
                checks += 2;
                if (out_grant !== g) begin failures++; $display("FAIL mon_grant act=%b exp=%b t=%0t", out_grant, g, $time); end
                if (out_v !== e_v) begin failures++; $display("FAIL mon_data act=%h exp=%h t=%0t", out_v, e_v, $time); end
                lg_grant.push_back(g);
                lg_full1.push_back(n1);
                if (g) m_cnt1++; else m_cnt0++;
                if (g == m_ptr) begin
                    if (m_burst < MB) m_burst++;
                end else begin
                    m_ptr   = g;
                    m_burst = 1;
                end
            end
            if (rst) begin
                m_q0.delete(); m_q1.delete();
                m_ptr = 1'b0; m_burst = 0; m_cnt0 = '0; m_cnt1 = '0;
            end else begin
                if (in0_ena && in0_rdy) m_q0.push_back(in0_v);
                if (in1_ena && in1_rdy) m_q1.push_back(in1_v);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (idle === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst     = 1'b0;
        out_rdy = 1'b1;
        mon_en  = 1'b1;
        #1;
        checks += 7;
        if (in0_rdy !== 1'b1) begin failures++; $display("FAIL reset_in0_rdy act=%b exp=1", in0_rdy); end
        if (in1_rdy !== 1'b1) begin failures++; $display("FAIL reset_in1_rdy act=%b exp=1", in1_rdy); end
        if (out_ena !== 1'b0) begin failures++; $display("FAIL reset_out_ena act=%b exp=0", out_ena); end
        if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle act=%b exp=1", idle); end
        if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin failures++; $display("FAIL reset_counts act=%0d/%0d exp=0/0", cnt0, cnt1); end
        if (out_v !== '0) begin failures++; $display("FAIL reset_out_v act=%h exp=0", out_v); end
        if (out_grant !== 1'b0) begin failures++; $display("FAIL reset_grant act=%b exp=0", out_grant); end
    endtask

    task automatic test_single_latency();
        logic [W-1:0] v;
        v = W'(8'hA5);
        in0_ena = 1'b1;
        in0_v   = v;
        tick();
        in0_ena = 1'b0;
        checks += 3;
        if (out_ena !== 1'b1) begin failures++; $display("FAIL lat_ena act=%b exp=1", out_ena); end
        if (out_v !== v) begin failures++; $display("FAIL lat_data act=%h exp=%h", out_v, v); end
        if (out_grant !== 1'b0) begin failures++; $display("FAIL lat_grant act=%b exp=0", out_grant); end
        tick();
        checks += 2;
        if (out_ena !== 1'b0) begin failures++; $display("FAIL lat_ena_after act=%b exp=0", out_ena); end
        if (cnt0 !== 16'd1) begin failures++; $display("FAIL lat_cnt0 act=%0d exp=1", cnt0); end
    endtask

    task automatic test_alternate();
        bit eg;
        bit ok;
        eg      = 1'b0;
        in0_ena = 1'b1; in0_v = rnd();
        in1_ena = 1'b1; in1_v = rnd();
        tick();
        for (int c = 0; c < 16; c++) begin
            checks++;
            if (out_ena !== 1'b1 || out_grant !== eg) begin
                failures++;
                $display("FAIL alt_grant cycle=%0d act=ena%b/g%b exp=ena1/g%b", c, out_ena, out_grant, eg);
            end
            eg      = ~eg;
            in0_ena = in0_rdy; in0_v = rnd();
            in1_ena = in1_rdy; in1_v = rnd();
            tick();
        end
        in0_ena = 1'b0;
        in1_ena = 1'b0;
        drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL alt_drain act=busy exp=idle"); end
    endtask

    task automatic test_burst_limit();
        int  start, run, max_run;
        bit  ok;
        for (int i = 0; i < 4; i++) begin
            in0_ena = 1'b1; in0_v = rnd();
            tick();
            in0_ena = 1'b0;
            tick();
        end
        start   = lg_grant.size();
        out_rdy = 1'b0;
        in0_ena = 1'b1; in0_v = rnd();
        in1_ena = 1'b1; in1_v = rnd();
        tick();
        in0_ena = 1'b0;
        in1_ena = 1'b0;
        checks += 2;
        if (out_ena !== 1'b0) begin failures++; $display("FAIL burst_hold_ena act=%b exp=0", out_ena); end
        if (out_grant !== 1'b1) begin failures++; $display("FAIL burst_pending_grant act=%b exp=1", out_grant); end
        out_rdy = 1'b1;
        #1;
        checks++;
        if (out_ena !== 1'b1 || out_grant !== 1'b1) begin
            failures++;
            $display("FAIL burst_switch act=ena%b/g%b exp=ena1/g1", out_ena, out_grant);
        end
        for (int c = 0; c < 12; c++) begin
            in0_ena = in0_rdy; in0_v = rnd();
            in1_ena = in1_rdy; in1_v = rnd();
            tick();
        end
        in0_ena = 1'b0;
        in1_ena = 1'b0;
        drain(ok);
        run = 0;
        max_run = 0;
        for (int i = start; i < lg_grant.size(); i++) begin
            if (!lg_grant[i] && lg_full1[i]) run++;
            else run = 0;
            if (run > max_run) max_run = run;
        end
        checks += 2;
        if (!ok) begin failures++; $display("FAIL burst_drain act=busy exp=idle"); end
        if (max_run > MB) begin failures++; $display("FAIL burst_run act=%0d exp<=%0d", max_run, MB); end
    endtask

    task automatic test_backpressure();
        in0_ena = 1'b1; in0_v = rnd();
        tick(); in0_ena = 1'b0; tick();
        in1_ena = 1'b1; in1_v = rnd();
        tick(); in1_ena = 1'b0; tick();
        out_rdy = 1'b0;
        in0_ena = 1'b1; in0_v = rnd();
        in1_ena = 1'b1; in1_v = rnd();
        tick();
        in0_ena = 1'b0;
        in1_ena = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_ena !== 1'b0 || in0_rdy !== 1'b0 || in1_rdy !== 1'b0) begin
                failures++;
                $display("FAIL bp_stall cycle=%0d act=ena%b/r0%b/r1%b exp=ena0/r00/r10", c, out_ena, in0_rdy, in1_rdy);
            end
            tick();
        end
        out_rdy = 1'b1;
        #1;
        checks++;
        if (out_ena !== 1'b1 || out_grant !== 1'b1) begin failures++; $display("FAIL bp_first act=ena%b/g%b exp=ena1/g1", out_ena, out_grant); end
        tick();
        checks++;
        if (out_ena !== 1'b1 || out_grant !== 1'b0) begin failures++; $display("FAIL bp_second act=ena%b/g%b exp=ena1/g0", out_ena, out_grant); end
        tick();
        checks++;
        if (out_ena !== 1'b0) begin failures++; $display("FAIL bp_done act=%b exp=0", out_ena); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] v;
        out_rdy = 1'b0;
        in0_ena = 1'b1; in0_v = rnd();
        in1_ena = 1'b1; in1_v = rnd();
        tick();
        in0_ena = 1'b0;
        in1_ena = 1'b0;
        rst     = 1'b1;
        out_rdy = 1'b1;
        #1;
        checks += 2;
        if (out_ena !== 1'b0) begin failures++; $display("FAIL rstmid_ena act=%b exp=0", out_ena); end
        if (idle !== 1'b1) begin failures++; $display("FAIL rstmid_idle act=%b exp=1", idle); end
        tick();
        rst = 1'b0;
        checks += 3;
        if (idle !== 1'b1) begin failures++; $display("FAIL rstmid_idle_after act=%b exp=1", idle); end
        if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin failures++; $display("FAIL rstmid_counts act=%0d/%0d exp=0/0", cnt0, cnt1); end
        if (out_ena !== 1'b0) begin failures++; $display("FAIL rstmid_ena_after act=%b exp=0", out_ena); end
        rst     = 1'b1;
        in0_ena = 1'b1; in0_v = rnd();
        tick();
        rst     = 1'b0;
        in0_ena = 1'b0;
        checks++;
        if (idle !== 1'b1 || in0_rdy !== 1'b1) begin failures++; $display("FAIL rst_enq_ignored act=idle%b/r0%b exp=idle1/r01", idle, in0_rdy); end
        v = rnd();
        in1_ena = 1'b1; in1_v = v;
        tick();
        in1_ena = 1'b0;
        checks++;
        if (out_ena !== 1'b1 || out_grant !== 1'b1 || out_v !== v) begin
            failures++;
            $display("FAIL rstmid_new act=ena%b/g%b/%h exp=ena1/g1/%h", out_ena, out_grant, out_v, v);
        end
        tick();
    endtask

    task automatic test_counter_wrap();
        for (int i = 0; i < 17; i++) begin
            in0_ena = 1'b1; in0_v = rnd();
            tick();
            in0_ena = 1'b0;
            tick();
        end
        checks += 3;
        if (s_cnt0 !== 4'd1) begin failures++; $display("FAIL wrap_cnt0_narrow act=%0d exp=1", s_cnt0); end
        if (s_cnt1 !== 4'd1) begin failures++; $display("FAIL wrap_cnt1_narrow act=%0d exp=1", s_cnt1); end
        if (cnt0 !== 16'd17) begin failures++; $display("FAIL wrap_cnt0_wide act=%0d exp=17", cnt0); end
    endtask

    initial begin
        test_reset();
        test_single_latency();
        test_alternate();
        test_burst_limit();
        test_backpressure();
        test_reset_mid();
        test_counter_wrap();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
